// File: rtl/ror32_if.sv
// Request/response bundle for the iterative rotate-right unit.
// The master issues start/Ra/shift_amt; the slave returns busy/done/result.
interface ror32_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
);
  logic             start;
  logic [WIDTH-1:0] Ra;
  logic [AMT_W-1:0] shift_amt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, Ra, shift_amt,
    input  busy, done, result
  );

  modport slave (
    input  start, Ra, shift_amt,
    output busy, done, result
  );
endinterface

// File: rtl/ror32_seq.sv
// Iterative rotate-right: coarse rotations by COARSE bits while the remaining
// amount allows, then single-bit rotations; done pulses once per operation.
module ror32_seq #(
  parameter int WIDTH  = 32,
  parameter int AMT_W  = 5,
  parameter int COARSE = 4
) (
  input  logic    clock,
  input  logic    clear,
  ror32_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_work;
  logic [AMT_W-1:0] step_cnt;

  // One rotation step: the largest step that does not overshoot the remaining amount.
  always_comb begin
    if (cnt_q >= AMT_W'(COARSE)) begin
      step_work = {work_q[COARSE-1:0], work_q[WIDTH-1:COARSE]};
      step_cnt  = cnt_q - AMT_W'(COARSE);
    end else begin
      step_work = {work_q[0], work_q[WIDTH-1:1]};
      step_cnt  = cnt_q - AMT_W'(1);
    end
  end

  always_comb begin
    // NOTE: every _d gets a hold/default value first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d = bus.Ra;
          cnt_d  = bus.shift_amt;
          busy_d = 1'b1;
          if (bus.shift_amt == '0) begin
            state_d  = DONE;
            result_d = bus.Ra;
            done_d   = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        work_d = step_work;
        cnt_d  = step_cnt;
        if (step_cnt == '0) begin
          state_d  = DONE;
          result_d = step_work;
          done_d   = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_ror32_seq.sv
// Self-checking bench for ror32_seq: directed vector table, multi-cycle corner
// sequences, and a randomized scoreboard against a reference rotate model.
module tb_ror32_seq;

  logic clock = 1'b0;
  logic clear = 1'b0;

  always #5 clock = ~clock;

  ror32_if #(.WIDTH(32), .AMT_W(5)) bus ();

  ror32_seq #(.WIDTH(32), .AMT_W(5), .COARSE(4)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] ra;
    logic [4:0]  amt;
    logic [31:0] exp_res;
    int          exp_cyc;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } sb_t;

  int          checks = 0;
  int          errors = 0;
  sb_t         sb_q[$];
  logic [31:0] prev_res = '0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ror_model(input logic [31:0] x, input int n);
    logic [63:0] dbl;
    dbl = {x, x} >> n;
    return dbl[31:0];
  endfunction

  // Issues one request in the current IDLE cycle and follows it to completion.
  // With poke set, start is held high with junk operands for the whole busy period.
  task automatic run_op(input logic [31:0] ra, input logic [4:0] amt,
                        input logic [31:0] exp_res, input int exp_cyc, input bit poke);
    sb_t exp;
    bit  got;
    sb_q.push_back('{res: exp_res, cyc: exp_cyc});
    bus.start     = 1'b1;
    bus.Ra        = ra;
    bus.shift_amt = amt;
    tick();
    got = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (poke) begin
        bus.start     = 1'b1;
        bus.Ra        = 32'hFFFF_FFFF;
        bus.shift_amt = 5'd1;
      end else begin
        bus.start     = 1'b0;
        bus.Ra        = $urandom;
        bus.shift_amt = 5'($urandom);
      end
      check("busy_during_op", {31'b0, bus.busy}, 32'd1);
      if (bus.done) begin
        exp = sb_q.pop_front();
        check("result", bus.result, exp.res);
        check("done_cycle", 32'(c), 32'(exp.cyc));
        prev_res = exp.res;
        got = 1'b1;
        break;
      end
      check("result_held", bus.result, prev_res);
      tick();
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within 40 cycles, expected cycle %0d", exp_cyc);
      if (sb_q.size() > 0) exp = sb_q.pop_front();
    end
    tick();
    bus.start = 1'b0;
    check("idle_busy", {31'b0, bus.busy}, 32'd0);
    check("idle_done", {31'b0, bus.done}, 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int          done_seen;
    logic [31:0] r_ra;
    int          r_amt;

    vecs[0] = '{ra: 32'hF0F0_F0F0, amt: 5'd0,  exp_res: 32'hF0F0_F0F0, exp_cyc: 1};
    vecs[1] = '{ra: 32'hF0F0_F0F0, amt: 5'd4,  exp_res: 32'h0F0F_0F0F, exp_cyc: 2};
    vecs[2] = '{ra: 32'h1234_5678, amt: 5'd16, exp_res: 32'h5678_1234, exp_cyc: 5};
    vecs[3] = '{ra: 32'h1234_5678, amt: 5'd5,  exp_res: 32'hC091_A2B3, exp_cyc: 3};
    vecs[4] = '{ra: 32'hAAAA_AAAA, amt: 5'd31, exp_res: 32'h5555_5555, exp_cyc: 11};
    vecs[5] = '{ra: 32'h8000_0001, amt: 5'd1,  exp_res: 32'hC000_0000, exp_cyc: 2};

    bus.start     = 1'b1;
    bus.Ra        = 32'h1234_5678;
    bus.shift_amt = 5'd3;
    clear         = 1'b1;
    tick();
    tick();
    check("reset_busy",   {31'b0, bus.busy}, 32'd0);
    check("reset_done",   {31'b0, bus.done}, 32'd0);
    check("reset_result", bus.result, 32'h0);
    clear     = 1'b0;
    bus.start = 1'b0;
    tick();
    tick();
    check("post_reset_busy", {31'b0, bus.busy}, 32'd0);
    check("post_reset_done", {31'b0, bus.done}, 32'd0);

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].ra, vecs[i].amt, vecs[i].exp_res, vecs[i].exp_cyc, 1'b0);

    // Starts during SHIFT and DONE are ignored; the following IDLE cycle accepts.
    run_op(32'h1234_5678, 5'd16, 32'h5678_1234, 5, 1'b1);
    run_op(32'h8000_0001, 5'd1, 32'hC000_0000, 2, 1'b0);

    // Abort mid-operation with clear in cycle 4.
    bus.start     = 1'b1;
    bus.Ra        = 32'hDEAD_BEEF;
    bus.shift_amt = 5'd31;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_busy",   {31'b0, bus.busy}, 32'd0);
    check("abort_done",   {31'b0, bus.done}, 32'd0);
    check("abort_result", bus.result, 32'h0);
    done_seen = 0;
    for (int c = 0; c < 14; c++) begin
      if (bus.done) done_seen++;
      tick();
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    prev_res = 32'h0;

    for (int i = 0; i < 200; i++) begin
      r_ra  = $urandom;
      r_amt = $urandom_range(0, 31);
      run_op(r_ra, 5'(r_amt), ror_model(r_ra, r_amt), 1 + r_amt / 4 + r_amt % 4, 1'b0);
    end

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
